// File: rtl/rv32i_types.sv
// Shared RV32I core types: fetch-stage state encoding, the canonical NOP and
// address helpers used across pipeline stages.
package rv32i_types;

  typedef enum logic [1:0] {
    FS_REQ     = 2'b00,
    FS_HELD    = 2'b01,
    FS_DISCARD = 2'b10
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: load has priority over flush; otherwise hold.
// A flush clears only the valid bit, pc/instr keep their last contents.
module if_id_reg
  import rv32i_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        flush,
  input  logic [31:0] load_pc,
  input  logic [31:0] load_instr,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] instr
);

  logic        valid_r;
  logic [31:0] pc_r;
  logic [31:0] instr_r;

  // Pipeline register update with asynchronous reset to an invalid NOP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= 1'b0;
      pc_r    <= 32'h0000_0000;
      instr_r <= NOP_INSTR;
    end else if (load) begin
      valid_r <= 1'b1;
      pc_r    <= load_pc;
      instr_r <= load_instr;
    end else if (flush) begin
      valid_r <= 1'b0;
    end
  end

  assign valid = valid_r;
  assign pc    = pc_r;
  assign instr = instr_r;

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: fetch PC, instruction-memory handshake,
// one-entry skid buffer for stalled responses and redirect handling.
module fetch_stage
  import rv32i_types::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_address,
  output logic        imem_read,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr
);

  fetch_state_t state_r, state_s;
  logic [31:0]  req_addr_r, req_addr_s;
  logic [31:0]  buf_r, buf_s;
  logic [31:0]  pend_pc_r, pend_pc_s;
  logic         ifid_load_s;
  logic         ifid_flush_s;
  logic [31:0]  ifid_instr_s;
  logic [31:0]  target_s;
  logic [31:0]  addr_inc_s;

  assign target_s   = align_word(redirect_pc);
  assign addr_inc_s = req_addr_r + 32'd4;

  // Gated by rst so a pending request is abandoned the moment reset asserts.
  assign imem_read    = ~rst & (state_r != FS_HELD);
  assign imem_address = req_addr_r;

  // State and fetch-address registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= FS_REQ;
      req_addr_r <= RESET_PC;
      buf_r      <= 32'h0000_0000;
      pend_pc_r  <= 32'h0000_0000;
    end else begin
      state_r    <= state_s;
      req_addr_r <= req_addr_s;
      buf_r      <= buf_s;
      pend_pc_r  <= pend_pc_s;
    end
  end

  // Next-state and IF/ID control; redirect always wins over stall.
  always_comb begin
    state_s      = state_r;
    req_addr_s   = req_addr_r;
    buf_s        = buf_r;
    pend_pc_s    = pend_pc_r;
    ifid_load_s  = 1'b0;
    ifid_flush_s = 1'b0;
    ifid_instr_s = imem_rdata;
    case (state_r)
      FS_REQ: begin
        if (redirect) begin
          ifid_flush_s = 1'b1;
          if (imem_resp) begin
            req_addr_s = target_s;
          end else begin
            pend_pc_s = target_s;
            state_s   = FS_DISCARD;
          end
        end else if (imem_resp && !stall) begin
          ifid_load_s = 1'b1;
          req_addr_s  = addr_inc_s;
        end else if (imem_resp) begin
          buf_s   = imem_rdata;
          state_s = FS_HELD;
        end else if (!stall) begin
          ifid_flush_s = 1'b1;
        end else begin
          ifid_flush_s = 1'b0;
        end
      end
      FS_HELD: begin
        ifid_instr_s = buf_r;
        if (redirect) begin
          buf_s        = 32'h0000_0000;
          ifid_flush_s = 1'b1;
          req_addr_s   = target_s;
          state_s      = FS_REQ;
        end else if (!stall) begin
          ifid_load_s = 1'b1;
          req_addr_s  = addr_inc_s;
          state_s     = FS_REQ;
        end else begin
          state_s = FS_HELD;
        end
      end
      FS_DISCARD: begin
        // The in-flight response belongs to the flushed path; the latest target wins.
        ifid_flush_s = 1'b1;
        if (redirect) begin
          pend_pc_s = target_s;
        end else begin
          pend_pc_s = pend_pc_r;
        end
        if (imem_resp) begin
          req_addr_s = redirect ? target_s : pend_pc_r;
          state_s    = FS_REQ;
        end else begin
          state_s = FS_DISCARD;
        end
      end
      default: begin
        state_s = FS_REQ;
      end
    endcase
  end

  if_id_reg u_if_id_reg (
    .clk        (clk),
    .rst        (rst),
    .load       (ifid_load_s),
    .flush      (ifid_flush_s),
    .load_pc    (req_addr_r),
    .load_instr (ifid_instr_s),
    .valid      (if_id_valid),
    .pc         (if_id_pc),
    .instr      (if_id_instr)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed cycle table, hand-written reset
// and wrap sequences, then randomized traffic against a transaction-level model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_address;
  logic        imem_read;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_resp = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;

  int checks = 0;
  int errors = 0;

  fetch_stage #(.RESET_PC(32'h0000_0060)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_address (imem_address),
    .imem_read    (imem_read),
    .imem_rdata   (imem_rdata),
    .imem_resp    (imem_resp),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .if_id_valid  (if_id_valid),
    .if_id_pc     (if_id_pc),
    .if_id_instr  (if_id_instr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic        rd;
    logic [31:0] rpc;
    logic        rsp;
    logic [31:0] dat;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] ein;
    logic [31:0] eaddr;
    logic        erd;
  } vec_t;

  vec_t tbl[$];

  // Reference model: the fetch PC, a pending-redirect target with a "response
  // still owed to a flushed path" flag, a skid queue, and the decode-visible slot.
  logic [31:0] m_addr, m_pend, m_pc, m_instr;
  logic        m_discard, m_valid;
  logic [31:0] m_skid[$];

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a ^ 32'hC0DE_0000) + 32'h0000_0003;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_addr = 32'h60; m_pend = 32'h0; m_pc = 32'h0; m_instr = 32'h13;
    m_discard = 1'b0; m_valid = 1'b0; m_skid.delete();
  endtask

  task automatic model_step(input logic s, input logic rd, input logic [31:0] rpc,
                            input logic rsp, input logic [31:0] dat);
    logic [31:0] tgt;
    tgt = {rpc[31:2], 2'b00};
    if (m_discard) begin
      m_valid = 1'b0;
      if (rsp) begin
        m_addr = rd ? tgt : m_pend;
        m_discard = 1'b0;
      end
      if (rd) m_pend = tgt;
    end else if (m_skid.size() != 0) begin
      if (rd) begin
        m_skid.delete(); m_valid = 1'b0; m_addr = tgt;
      end else if (!s) begin
        m_valid = 1'b1; m_pc = m_addr; m_instr = m_skid.pop_front(); m_addr = m_addr + 32'd4;
      end
    end else if (rd) begin
      m_valid = 1'b0;
      if (rsp) m_addr = tgt;
      else begin m_pend = tgt; m_discard = 1'b1; end
    end else if (rsp) begin
      if (!s) begin m_valid = 1'b1; m_pc = m_addr; m_instr = dat; m_addr = m_addr + 32'd4; end
      else m_skid.push_back(dat);
    end else if (!s) begin
      m_valid = 1'b0;
    end
  endtask

  function automatic logic model_read();
    return m_skid.size() == 0;
  endfunction

  task automatic step(input logic s, input logic rd, input logic [31:0] rpc,
                      input logic rsp, input logic [31:0] dat);
    @(negedge clk);
    stall = s; redirect = rd; redirect_pc = rpc; imem_resp = rsp; imem_rdata = dat;
    @(posedge clk);
    model_step(s, rd, rpc, rsp, dat);
    #1;
  endtask

  task automatic add(input logic s, input logic rd, input logic [31:0] rpc, input logic rsp,
                     input logic [31:0] dat, input logic ev, input logic [31:0] epc,
                     input logic [31:0] ein, input logic [31:0] eaddr, input logic erd);
    vec_t v;
    v.s = s; v.rd = rd; v.rpc = rpc; v.rsp = rsp; v.dat = dat;
    v.ev = ev; v.epc = epc; v.ein = ein; v.eaddr = eaddr; v.erd = erd;
    tbl.push_back(v);
  endtask

  task automatic chk_model(input string tag);
    chk({tag, " valid"}, {31'h0, if_id_valid}, {31'h0, m_valid});
    chk({tag, " pc"}, if_id_pc, m_pc);
    chk({tag, " instr"}, if_id_instr, m_instr);
    chk({tag, " addr"}, imem_address, m_addr);
    chk({tag, " read"}, {31'h0, imem_read}, {31'h0, model_read()});
  endtask

  initial begin
    // stream, stall/HELD, redirect outstanding, double redirect, HELD redirect,
    // redirect on response, redirect during discard response, stall without response
    add(1'b0,1'b0,32'h0,1'b1,mem_data(32'h60),  1'b1,32'h60,mem_data(32'h60),32'h64,1'b1);
    add(1'b1,1'b0,32'h0,1'b1,mem_data(32'h64),  1'b1,32'h60,mem_data(32'h60),32'h64,1'b0);
    add(1'b1,1'b0,32'h0,1'b0,32'h0,             1'b1,32'h60,mem_data(32'h60),32'h64,1'b0);
    add(1'b1,1'b0,32'h0,1'b0,32'h0,             1'b1,32'h60,mem_data(32'h60),32'h64,1'b0);
    add(1'b0,1'b0,32'h0,1'b0,32'h0,             1'b1,32'h64,mem_data(32'h64),32'h68,1'b1);
    add(1'b0,1'b0,32'h0,1'b1,mem_data(32'h68),  1'b1,32'h68,mem_data(32'h68),32'h6C,1'b1);
    add(1'b0,1'b0,32'h0,1'b0,32'h0,             1'b0,32'h68,mem_data(32'h68),32'h6C,1'b1);
    add(1'b0,1'b0,32'h0,1'b1,mem_data(32'h6C),  1'b1,32'h6C,mem_data(32'h6C),32'h70,1'b1);
    add(1'b0,1'b0,32'h0,1'b0,32'h0,             1'b0,32'h6C,mem_data(32'h6C),32'h70,1'b1);
    add(1'b0,1'b1,32'h200,1'b0,32'h0,           1'b0,32'h6C,mem_data(32'h6C),32'h70,1'b1);
    add(1'b0,1'b0,32'h0,1'b0,32'h0,             1'b0,32'h6C,mem_data(32'h6C),32'h70,1'b1);
    add(1'b0,1'b0,32'h0,1'b1,mem_data(32'h70),  1'b0,32'h6C,mem_data(32'h6C),32'h200,1'b1);
    add(1'b0,1'b0,32'h0,1'b1,mem_data(32'h200), 1'b1,32'h200,mem_data(32'h200),32'h204,1'b1);
    add(1'b0,1'b1,32'h200,1'b0,32'h0,           1'b0,32'h200,mem_data(32'h200),32'h204,1'b1);
    add(1'b0,1'b1,32'h303,1'b0,32'h0,           1'b0,32'h200,mem_data(32'h200),32'h204,1'b1);
    add(1'b0,1'b0,32'h0,1'b1,mem_data(32'h204), 1'b0,32'h200,mem_data(32'h200),32'h300,1'b1);
    add(1'b0,1'b0,32'h0,1'b1,mem_data(32'h300), 1'b1,32'h300,mem_data(32'h300),32'h304,1'b1);
    add(1'b1,1'b0,32'h0,1'b1,mem_data(32'h304), 1'b1,32'h300,mem_data(32'h300),32'h304,1'b0);
    add(1'b1,1'b1,32'h400,1'b0,32'h0,           1'b0,32'h300,mem_data(32'h300),32'h400,1'b1);
    add(1'b0,1'b0,32'h0,1'b1,mem_data(32'h400), 1'b1,32'h400,mem_data(32'h400),32'h404,1'b1);
    add(1'b1,1'b1,32'h500,1'b1,mem_data(32'h404),1'b0,32'h400,mem_data(32'h400),32'h500,1'b1);
    add(1'b0,1'b0,32'h0,1'b1,mem_data(32'h500), 1'b1,32'h500,mem_data(32'h500),32'h504,1'b1);
    add(1'b0,1'b1,32'h600,1'b0,32'h0,           1'b0,32'h500,mem_data(32'h500),32'h504,1'b1);
    add(1'b0,1'b1,32'h700,1'b1,mem_data(32'h504),1'b0,32'h500,mem_data(32'h500),32'h700,1'b1);
    add(1'b0,1'b0,32'h0,1'b1,mem_data(32'h700), 1'b1,32'h700,mem_data(32'h700),32'h704,1'b1);
    add(1'b1,1'b0,32'h0,1'b0,32'h0,             1'b1,32'h700,mem_data(32'h700),32'h704,1'b1);
    add(1'b0,1'b0,32'h0,1'b1,mem_data(32'h704), 1'b1,32'h704,mem_data(32'h704),32'h708,1'b1);

    model_reset();
    #12;
    chk("reset read", {31'h0, imem_read}, 32'h0);
    chk("reset valid", {31'h0, if_id_valid}, 32'h0);
    chk("reset pc", if_id_pc, 32'h0);
    chk("reset instr", if_id_instr, 32'h13);
    chk("reset addr", imem_address, 32'h60);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("first read", {31'h0, imem_read}, 32'h1);

    foreach (tbl[i]) begin
      step(tbl[i].s, tbl[i].rd, tbl[i].rpc, tbl[i].rsp, tbl[i].dat);
      chk($sformatf("row%0d valid", i), {31'h0, if_id_valid}, {31'h0, tbl[i].ev});
      chk($sformatf("row%0d pc", i), if_id_pc, tbl[i].epc);
      chk($sformatf("row%0d instr", i), if_id_instr, tbl[i].ein);
      chk($sformatf("row%0d addr", i), imem_address, tbl[i].eaddr);
      chk($sformatf("row%0d read", i), {31'h0, imem_read}, {31'h0, tbl[i].erd});
    end

    // Reset with a request pending takes effect without a clock edge.
    @(negedge clk);
    imem_resp = 1'b0; redirect = 1'b0; stall = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("midrst read", {31'h0, imem_read}, 32'h0);
    chk("midrst instr", if_id_instr, 32'h13);
    chk("midrst valid", {31'h0, if_id_valid}, 32'h0);
    chk("midrst addr", imem_address, 32'h60);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("refetch read", {31'h0, imem_read}, 32'h1);
    chk("refetch addr", imem_address, 32'h60);
    step(1'b0, 1'b0, 32'h0, 1'b1, mem_data(32'h60));
    chk("refetch pc", if_id_pc, 32'h60);
    chk("refetch valid", {31'h0, if_id_valid}, 32'h1);

    step(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1, mem_data(32'h64));
    chk("wrap target", imem_address, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 32'h0, 1'b1, mem_data(32'hFFFF_FFFC));
    chk("wrap pc", if_id_pc, 32'hFFFF_FFFC);
    chk("wrap instr", if_id_instr, mem_data(32'hFFFF_FFFC));
    chk("wrap next", imem_address, 32'h0);
    chk_model("wrap model");

    for (int n = 0; n < 3000; n++) begin
      logic s, rd, rsp;
      logic [31:0] rpc, dat;
      s   = ($urandom_range(0, 9) < 3);
      rd  = ($urandom_range(0, 9) == 0);
      rpc = $urandom();
      rsp = model_read() && ($urandom_range(0, 1) == 1);
      dat = rsp ? mem_data(m_addr) : $urandom();
      step(s, rd, rpc, rsp, dat);
      chk_model($sformatf("rand%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined RV32I core. Holds the fetch PC and issues read requests to the instruction memory/cache port. It also owns the IF/ID pipeline register whose `pc`/`instr` outputs feed the decode stage, where the control ROM builds the control word. It handles downstream stall, branch/jump redirect, and redirects that arrive while a memory request is still outstanding.

## Interface
- `RESET_PC`, default 32'h00000060: first fetch address after reset.
- `clk` input 1: sole clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `imem_address` output 32: address of the outstanding request; word aligned.
- `imem_read` output 1: read request level; held until `imem_resp`.
- `imem_rdata` input 32: instruction word, valid only when `imem_resp` = 1.
- `imem_resp` input 1: one-cycle completion pulse for the current request.
- `stall` input 1: decode cannot accept; IF/ID must hold.
- `redirect` input 1: taken branch/jump from execute; flush and refetch.
- `redirect_pc` input 32: target address, sampled when `redirect` = 1.
- `if_id_valid` output 1: IF/ID holds a real instruction.
- `if_id_pc` output 32: PC of the IF/ID instruction.
- `if_id_instr` output 32: IF/ID instruction word.

## Operation
- Registers:
  - `req_addr` drives `imem_address`.
  - `pend_pc` holds a redirect target captured during DISCARD.
  - `buf` is a one-entry skid buffer.
  - The IF/ID register holds valid, pc and instr.
  - `state` ∈ {REQ, HELD, DISCARD}.
- `imem_read` = 1 in REQ and DISCARD, 0 in HELD, and forced 0 while `rst` is high.
- `req_addr` changes only in a cycle with `imem_resp` = 1, or while the stage is in HELD. The address is never changed mid-request.
- **REQ**, in priority order:
  - `redirect`: set IF/ID valid to 0. If `imem_resp`, set `req_addr` to `redirect_pc` and stay in REQ. Otherwise set `pend_pc` to `redirect_pc` and go to DISCARD.
  - `imem_resp` and not `stall`: load IF/ID with {1, `req_addr`, `imem_rdata`}, set `req_addr` to `req_addr`+4, stay in REQ.
  - `imem_resp` and `stall`: set `buf` to `imem_rdata`, go to HELD. IF/ID holds.
  - No response and not `stall`: set IF/ID valid to 0 (bubble).
  - No response and `stall`: IF/ID holds.
- **HELD**:
  - `redirect`: drop `buf`, set IF/ID valid to 0, set `req_addr` to `redirect_pc`, go to REQ.
  - Not `stall`: load IF/ID with {1, `req_addr`, `buf`}, set `req_addr` to `req_addr`+4, go to REQ.
  - Otherwise hold.
- **DISCARD**:
  - IF/ID valid stays 0.
  - A further `redirect` overwrites `pend_pc`; the latest target wins.
  - On `imem_resp`, drop the data, set `req_addr` to `pend_pc` (or to `redirect_pc` if `redirect` is high in the same cycle), go to REQ.
- `redirect` always overrides `stall`. The flush takes effect even while decode is stalled.
- PC arithmetic is 32-bit modulo: 32'hFFFFFFFC + 4 wraps to 0.
- `redirect_pc[1:0]` is ignored; the low bits are forced to 0.

## Timing
- Reset values:
  - `state` = REQ, `req_addr` = `RESET_PC`.
  - `if_id_valid` = 0, `if_id_pc` = 0, `if_id_instr` = 32'h00000013 (NOP).
  - `buf` = 0, `pend_pc` = 0.
- `imem_read` first rises in the first cycle after `rst` deasserts.
- Latency: `imem_resp` in cycle N gives a valid IF/ID in cycle N+1, unless stalled.
- The next request address is presented in cycle N+1.
- With a one-cycle memory, throughput is one instruction per cycle.
- Redirect in cycle N:
  - IF/ID is invalid in cycle N+1.
  - The target is fetched from cycle N+1 if no request was outstanding, or if the request completed in cycle N.
  - Otherwise the target is fetched in the cycle after the discarded response.
- Asserting `rst` mid-request abandons the request immediately; outputs go to their reset values asynchronously.

## Structure
- Add `fetch_state_t` (REQ, HELD, DISCARD) and the constant `NOP_INSTR` = 32'h00000013 to the shared `rv32i_types` package.
- One sub-module is natural: `if_id_reg`, a load/flush/hold pipeline register carrying valid, pc and instr.
- The FSM, `req_addr`, `buf` and `pend_pc` stay in `fetch_stage`.

## Test plan
- **Reset and one-cycle stream.** Release reset; the memory responds one cycle after each request.
  - Required: addresses 0x60, 0x64, 0x68 in consecutive cycles.
  - Required: IF/ID shows pc 0x60/0x64/0x68 with matching data, one cycle after each response.
- **Stall on response.** Response at 0x64 with `stall`=1 for 3 cycles.
  - Required: state HELD, `imem_read`=0, IF/ID unchanged.
  - On release: IF/ID = {0x64, data}, then request 0x68.
- **Redirect with request outstanding.** Request to 0x70 pending; `redirect` to 0x200.
  - Required: IF/ID valid 0 next cycle; `imem_address` stays 0x70 until the response.
  - Required: 0x70 data is never presented; the next request is 0x200.
- **Double redirect in DISCARD.** Redirect to 0x200, then to 0x300 before the response.
  - Required: the first address fetched after the response is 0x300.
- **Redirect versus stall, and HELD redirect.**
  - In HELD with `stall`=1: `redirect` to 0x400 flushes `buf`, IF/ID valid 0, next request 0x400.
  - Required: the same result if the redirect coincides with `imem_resp`.
- **Mid-operation reset and wrap.**
  - Assert `rst` with a request pending: `imem_read`=0 and `if_id_instr`=0x13 immediately; refetch from 0x60 after release.
  - Redirect to 0xFFFFFFFC: the next sequential fetch is 0x00000000.
